clearable_ram: RTL and testbench
================================

# clearable_ram

Parametrised single-write, single-read synchronous RAM with registered read data, a read-valid pipeline of configurable latency, and a built-in clear engine that fills every entry with a constant. It succeeds the plain `RandomAccessMemory` as the storage primitive for iteration-count and line buffers in the Mandelbrot pipeline. Consumers use it when a frame buffer must be zeroed after reset, or on demand between frames, without an external sweep.

## Interface
- `DATA_WIDTH`, 8, width of one word.
- `ADDR_WIDTH`, 4, address width; depth is 2^ADDR_WIDTH.
- `READ_LATENCY`, 1, read pipeline depth in cycles; only 1 or 2 are legal.
- `CLEAR_VALUE`, 0, DATA_WIDTH-bit value written by the clear engine.
- `clock` input 1: single clock; all logic is rising-edge.
- `reset` input 1: synchronous, active-high.
- `clear_start` input 1: one-cycle request to clear the whole array.
- `busy` output 1: high while the clear engine owns the array.
- `wr_enable` input 1: write strobe.
- `wr_addr` input ADDR_WIDTH: write address.
- `wr_data` input DATA_WIDTH: write data.
- `rd_enable` input 1: read request.
- `rd_addr` input ADDR_WIDTH: read address.
- `rd_data` output DATA_WIDTH: registered read data.
- `rd_valid` output 1: `rd_data` carries the result of an accepted read.

## Operation
- The FSM has two states, IDLE and CLEAR, and a clear counter `clr_addr` of ADDR_WIDTH bits.
- Reset:
  - At any rising edge with `reset`=1: state becomes CLEAR, `clr_addr` becomes 0, `busy` is 1, `rd_valid` is 0, `rd_data` is 0.
  - The read pipeline is flushed.
  - The array is not written on the reset edge itself.
- CLEAR state:
  - Each edge writes CLEAR_VALUE to `clr_addr` and increments it.
  - At the edge that writes address 2^ADDR_WIDTH-1, the FSM moves to IDLE and `busy` falls. `clr_addr` wraps to 0.
- IDLE state: a `clear_start`=1 sampled at an edge moves the FSM to CLEAR with `clr_addr`=0. `busy` rises at that edge.
- While `busy`=1, `wr_enable`, `rd_enable` and `clear_start` are ignored. No user write lands, and no `rd_valid` is generated for requests sampled while `busy`=1.
- In IDLE:
  - `wr_enable`=1 writes `wr_data` to `wr_addr` at the edge.
  - `rd_enable`=1 launches a read of `rd_addr`.
- Requests sampled together with `clear_start`: user reads and writes sampled in the same IDLE edge as `clear_start` are still accepted. A read launched there returns pre-clear data.
- Reads already in flight when a clear starts complete normally.
- `rd_data` holds its last value whenever `rd_valid`=0.
- A read and a write to the same address in the same cycle resolve per the Configuration section. Reads and writes to different addresses never interact.

## Timing
- Read latency:
  - `rd_enable` sampled at edge N gives `rd_data`/`rd_valid` updated at edge N+READ_LATENCY.
  - `rd_valid` is high for exactly one cycle per accepted request.
  - Back-to-back reads give back-to-back valid results.
- Clear duration: after `reset` falls, `busy` stays high for exactly 2^ADDR_WIDTH cycles. The first user access is accepted at edge 2^ADDR_WIDTH after the first non-reset edge.
- On-demand clear: `clear_start` at edge N gives `busy` high from edge N through edge N+2^ADDR_WIDTH.
- Write-to-read: data written at edge N is visible to a read launched at edge N+1 or later.
- Reset mid-clear restarts the sweep at address 0 with the full duration.
- Reset with reads in flight: those reads never assert `rd_valid`.

## Configuration
- Macro `CLEARABLE_RAM_BYPASS_EN` selects same-address read/write behaviour.
- Defined (write-first): when a read and a write hit the same address in the same accepted cycle, the read returns the new `wr_data`.
- Undefined (read-first): the read returns the old contents. No forwarding logic is built.
- CLEAR-state writes never forward in either mode, because reads are blocked while `busy`=1.

## Test plan
All scenarios use DATA_WIDTH=8, ADDR_WIDTH=4, CLEAR_VALUE=0x00.
- Reset clear: assert `reset` 2 cycles, then release. Required: `busy` high exactly 16 cycles; afterwards reads of 0x0..0xF all return 0x00 with `rd_valid` READ_LATENCY cycles after each request.
- Basic access (READ_LATENCY=1 and 2):
  - Write 0xFF to 0xA, then read 0xA the next cycle. Required: `rd_data`=0xFF with `rd_valid` one pulse, exactly READ_LATENCY edges later.
  - Back-to-back reads of 0xA and 0x3 give 0xFF then 0x00 on consecutive cycles.
- Same-cycle collision: 0x5 holds 0x11; write 0x22 to 0x5 and read 0x5 in the same cycle. Required: 0x22 with the macro defined, 0x11 without; a later read returns 0x22 in both builds.
- Clear on demand:
  - Fill all 16 entries with 0xA5, then pulse `clear_start`. Required: `busy` high for 16 cycles, then all entries read back 0x00.
  - A write to 0x2 and a read issued while `busy`=1 produce no array change and no `rd_valid`.
- Reset mid-clear: pulse `clear_start`, then assert `reset` for one cycle after 7 clear cycles. Required: `busy` stays high and the sweep restarts from 0, falling 16 cycles after reset release; no `rd_valid` pulses from reads in flight at the reset.

Source files
------------

// File: rtl/clearable_ram.sv
// ----------------------------------------------------------------------------
// clearable_ram: 1W/1R synchronous RAM with registered read data, a 1- or
// 2-cycle read-valid pipeline, and a built-in engine that fills every entry
// with CLEAR_VALUE after reset or on request.
// Optional feature macro: CLEARABLE_RAM_BYPASS_EN (write-first same-address
// read/write); undefined builds read-first with no forwarding logic.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module clearable_ram #(
  parameter int                    DATA_WIDTH   = 8,
  parameter int                    ADDR_WIDTH   = 4,
  parameter int                    READ_LATENCY = 1,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE  = '0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clear_start,
  output logic                  busy,
  input  logic                  wr_enable,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_enable,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t                  state;
  state_t                  state_next;
  logic [ADDR_WIDTH-1:0]   clr_addr;
  logic [ADDR_WIDTH-1:0]   clr_addr_next;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic                    wr_accept;
  logic                    rd_accept;
  logic [DATA_WIDTH-1:0]   rd_word;
  logic                    pipe_valid;
  logic [DATA_WIDTH-1:0]   pipe_data;

  assign busy      = (state == CLEAR);
  assign wr_accept = wr_enable && !busy;
  assign rd_accept = rd_enable && !busy;

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= CLEAR;
      clr_addr <= '0;
    end else begin
      state    <= state_next;
      clr_addr <= clr_addr_next;
    end
  end

  always_comb begin
    state_next    = state;
    clr_addr_next = clr_addr;
    case (state)
      IDLE: begin
        if (clear_start) begin
          state_next    = CLEAR;
          clr_addr_next = '0;
        end
      end
      CLEAR: begin
        clr_addr_next = clr_addr + 1'b1;
        if (clr_addr == LAST_ADDR) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // The reset edge itself must leave the array untouched.
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (busy) begin
        mem[clr_addr] <= CLEAR_VALUE;
      end else if (wr_accept) begin
        mem[wr_addr] <= wr_data;
      end
    end
  end

`ifdef CLEARABLE_RAM_BYPASS_EN
  assign rd_word = (wr_accept && (wr_addr == rd_addr)) ? wr_data : mem[rd_addr];
`else
  assign rd_word = mem[rd_addr];
`endif

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic                  s1_valid;
      logic [DATA_WIDTH-1:0] s1_data;

      always_ff @(posedge clock) begin
        if (reset) begin
          s1_valid <= 1'b0;
          s1_data  <= '0;
        end else begin
          s1_valid <= rd_accept;
          if (rd_accept) begin
            s1_data <= rd_word;
          end
        end
      end

      assign pipe_valid = s1_valid;
      assign pipe_data  = s1_data;
    end else begin : g_lat1
      assign pipe_valid = rd_accept;
      assign pipe_data  = rd_word;
    end
  endgenerate

  // Output data only moves with a valid result, so it holds otherwise.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= pipe_valid;
      if (pipe_valid) begin
        rd_data <= pipe_data;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_clearable_ram.sv
// ----------------------------------------------------------------------------
// tb_clearable_ram: directed self-checking bench driving a latency-1 and a
// latency-2 instance of clearable_ram with identical stimulus.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_clearable_ram;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       clear_start = 1'b0;
  logic       wr_enable = 1'b0;
  logic [3:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic       rd_enable = 1'b0;
  logic [3:0] rd_addr = '0;

  logic       busy1, busy2;
  logic [7:0] rd_data1, rd_data2;
  logic       rd_valid1, rd_valid2;

  int checks = 0;
  int errors = 0;
  int n;

  always #5 clock = ~clock;

  clearable_ram #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .READ_LATENCY(1), .CLEAR_VALUE(8'h00)) u_l1 (
    .clock(clock), .reset(reset), .clear_start(clear_start), .busy(busy1),
    .wr_enable(wr_enable), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_enable(rd_enable), .rd_addr(rd_addr), .rd_data(rd_data1), .rd_valid(rd_valid1)
  );

  clearable_ram #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .READ_LATENCY(2), .CLEAR_VALUE(8'h00)) u_l2 (
    .clock(clock), .reset(reset), .clear_start(clear_start), .busy(busy2),
    .wr_enable(wr_enable), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_enable(rd_enable), .rd_addr(rd_addr), .rd_data(rd_data2), .rd_valid(rd_valid2)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Single read, checked on both instances at their own latencies.
  task automatic read_check(input logic [3:0] addr, input logic [7:0] exp);
    rd_enable = 1'b1;
    rd_addr   = addr;
    step();
    rd_enable = 1'b0;
    chk("l1_valid", rd_valid1, 1);
    chk("l1_data", rd_data1, exp);
    chk("l2_valid_early", rd_valid2, 0);
    step();
    chk("l1_valid_pulse", rd_valid1, 0);
    chk("l2_valid", rd_valid2, 1);
    chk("l2_data", rd_data2, exp);
  endtask

  task automatic write(input logic [3:0] addr, input logic [7:0] data);
    wr_enable = 1'b1;
    wr_addr   = addr;
    wr_data   = data;
    step();
    wr_enable = 1'b0;
  endtask

  // Steps until busy falls, counting edges; no read result may appear.
  task automatic wait_idle(input int start, output int cnt);
    cnt = start;
    for (int i = 0; i < 40; i++) begin
      step();
      cnt++;
      chk("busy_match", busy1, busy2);
      chk("l1_no_valid", rd_valid1, 0);
      chk("l2_no_valid", rd_valid2, 0);
      if (!busy1) break;
    end
  endtask

  initial begin
    // Reset clear
    reset = 1'b1;
    step();
    step();
    chk("rst_busy1", busy1, 1);
    chk("rst_busy2", busy2, 1);
    chk("rst_valid1", rd_valid1, 0);
    chk("rst_valid2", rd_valid2, 0);
    chk("rst_data1", rd_data1, 8'h00);
    chk("rst_data2", rd_data2, 8'h00);
    reset = 1'b0;
    wait_idle(0, n);
    chk("rst_busy_len", n, 16);
    for (int a = 0; a < 16; a++) read_check(4'(a), 8'h00);

    // Basic access
    write(4'hA, 8'hFF);
    read_check(4'hA, 8'hFF);

    // Back-to-back reads
    rd_enable = 1'b1;
    rd_addr   = 4'hA;
    step();
    chk("b2b_l1_v0", rd_valid1, 1);
    chk("b2b_l1_d0", rd_data1, 8'hFF);
    rd_addr = 4'h3;
    step();
    rd_enable = 1'b0;
    chk("b2b_l1_v1", rd_valid1, 1);
    chk("b2b_l1_d1", rd_data1, 8'h00);
    chk("b2b_l2_v0", rd_valid2, 1);
    chk("b2b_l2_d0", rd_data2, 8'hFF);
    step();
    chk("b2b_l1_v2", rd_valid1, 0);
    chk("b2b_l1_hold", rd_data1, 8'h00);
    chk("b2b_l2_v1", rd_valid2, 1);
    chk("b2b_l2_d1", rd_data2, 8'h00);
    step();
    chk("b2b_l2_v2", rd_valid2, 0);
    chk("b2b_l2_hold", rd_data2, 8'h00);

    // Same-cycle collision
    write(4'h5, 8'h11);
    wr_enable = 1'b1;
    wr_addr   = 4'h5;
    wr_data   = 8'h22;
    rd_enable = 1'b1;
    rd_addr   = 4'h5;
    step();
    wr_enable = 1'b0;
    rd_enable = 1'b0;
`ifdef CLEARABLE_RAM_BYPASS_EN
    chk("coll_l1", rd_data1, 8'h22);
    step();
    chk("coll_l2", rd_data2, 8'h22);
`else
    chk("coll_l1", rd_data1, 8'h11);
    step();
    chk("coll_l2", rd_data2, 8'h11);
`endif
    read_check(4'h5, 8'h22);

    // Clear on demand, with a read accepted on the clear_start edge
    for (int a = 0; a < 16; a++) write(4'(a), 8'hA5);
    clear_start = 1'b1;
    rd_enable   = 1'b1;
    rd_addr     = 4'h7;
    step();
    clear_start = 1'b0;
    rd_enable   = 1'b0;
    chk("clr_busy_rise", busy1, 1);
    chk("clr_pre_l1_v", rd_valid1, 1);
    chk("clr_pre_l1_d", rd_data1, 8'hA5);
    step();
    chk("clr_pre_l2_v", rd_valid2, 1);
    chk("clr_pre_l2_d", rd_data2, 8'hA5);
    chk("clr_l1_quiet", rd_valid1, 0);
    for (int i = 0; i < 8; i++) step();
    // Clear already swept address 2; these must be ignored.
    wr_enable = 1'b1;
    wr_addr   = 4'h2;
    wr_data   = 8'h77;
    rd_enable = 1'b1;
    rd_addr   = 4'h2;
    wait_idle(9, n);
    wr_enable = 1'b0;
    rd_enable = 1'b0;
    chk("clr_busy_len", n, 16);
    for (int a = 0; a < 16; a++) read_check(4'(a), 8'h00);

    // Reset mid-clear
    clear_start = 1'b1;
    step();
    clear_start = 1'b0;
    for (int i = 0; i < 7; i++) step();
    chk("mid_busy", busy1, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mid_rst_busy1", busy1, 1);
    chk("mid_rst_busy2", busy2, 1);
    wait_idle(0, n);
    chk("mid_busy_len", n, 16);

    // Reset with a read in flight in the latency-2 pipeline
    write(4'hC, 8'h3C);
    rd_enable = 1'b1;
    rd_addr   = 4'hC;
    step();
    rd_enable = 1'b0;
    chk("fl_l1_v", rd_valid1, 1);
    chk("fl_l1_d", rd_data1, 8'h3C);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("fl_l2_v", rd_valid2, 0);
    chk("fl_l2_d", rd_data2, 8'h00);
    chk("fl_l1_d_rst", rd_data1, 8'h00);
    wait_idle(0, n);
    chk("fl_busy_len", n, 16);
    read_check(4'hC, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
